// File: rtl/antiglitch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : antiglitch_bank_ctrl
// Purpose  : Round-robin N-of-M antiglitch filter shared across CH channels,
//            with frame-aligned runtime N/M and a valid/ready change-event port.
//            Define ANTIGLITCH_BANK_CTRL_IRQ_EN to add sticky per-channel irq flags.
// Revision : 1.0 - initial release
// ============================================================================
module antiglitch_bank_ctrl #(
    parameter int CH    = 8,
    parameter int MMAX  = 16,
    parameter int N_DEF = 3,
    parameter int M_DEF = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH-1:0]           glitch,
    input  logic                    cfg_we,
    input  logic [$clog2(MMAX):0]   cfg_n,
    input  logic [$clog2(MMAX):0]   cfg_m,
    output logic [CH-1:0]           clean,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(CH)-1:0]   evt_ch,
    output logic                    evt_level,
    output logic                    frame_start
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
    ,
    output logic [CH-1:0]           irq_pend,
    input  logic [CH-1:0]           irq_clr,
    output logic                    irq
`endif
);

    localparam int              C_CW   = $clog2(MMAX) + 1;
    localparam int              C_PW   = $clog2(CH);
    localparam logic [C_PW-1:0] C_LAST = C_PW'(CH - 1);
    localparam logic [C_CW-1:0] C_MMAX = C_CW'(MMAX);
    localparam logic [C_CW-1:0] C_NDEF = C_CW'(N_DEF);
    localparam logic [C_CW-1:0] C_MDEF = C_CW'(M_DEF);

    // Channel scheduler and per-channel state
    logic [C_PW-1:0]            ptr_q, ptr_d;
    logic [CH-1:0][MMAX-1:0]    hist_q, hist_d;
    logic [CH-1:0]              clean_q, clean_d;

    // Pending and active configuration (raw, clamped at use)
    logic [C_CW-1:0]            n_pend_q, n_pend_d;
    logic [C_CW-1:0]            m_pend_q, m_pend_d;
    logic [C_CW-1:0]            n_act_q, n_act_d;
    logic [C_CW-1:0]            m_act_q, m_act_d;

    // Event port and frame marker
    logic                       evt_valid_q, evt_valid_d;
    logic [C_PW-1:0]            evt_ch_q, evt_ch_d;
    logic                       evt_level_q, evt_level_d;
    logic                       frame_start_q, frame_start_d;

    // Evaluation datapath
    logic                       w_stall;
    logic                       w_wrap;
    logic [C_CW-1:0]            w_m_eff;
    logic [C_CW-1:0]            w_n_eff;
    logic [MMAX-1:0]            w_new_hist;
    logic                       w_sample;
    logic                       w_cur_clean;
    logic [C_CW-1:0]            w_dist;
    logic                       w_toggle;

    assign w_stall     = evt_valid_q && !evt_ready;
    assign w_wrap      = !w_stall && (ptr_q == C_LAST);
    assign w_m_eff     = (m_act_q > C_MMAX) ? C_MMAX : m_act_q;
    assign w_n_eff     = (n_act_q == '0) ? C_CW'(1) : n_act_q;
    assign w_sample    = glitch[ptr_q];
    assign w_cur_clean = clean_q[ptr_q];
    assign w_new_hist  = {hist_q[ptr_q][MMAX-2:0], w_sample};

    // Disagreement count over the active window of the post-shift history
    always_comb begin
        w_dist = '0;
        for (int i = 0; i < MMAX; i++) begin
            if ((C_CW'(i) < w_m_eff) && (w_new_hist[i] != w_cur_clean)) begin
                w_dist = w_dist + C_CW'(1);
            end
        end
    end

    // Windows shorter than two samples degrade to pass-through; otherwise
    // d >= N can only hold when N <= M, so N > M never toggles.
    always_comb begin
        if (w_m_eff < C_CW'(2)) begin
            w_toggle = (w_sample != w_cur_clean);
        end else begin
            w_toggle = (w_dist >= w_n_eff);
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        hist_d        = hist_q;
        clean_d       = clean_q;
        n_pend_d      = n_pend_q;
        m_pend_d      = m_pend_q;
        n_act_d       = n_act_q;
        m_act_d       = m_act_q;
        evt_valid_d   = evt_valid_q;
        evt_ch_d      = evt_ch_q;
        evt_level_d   = evt_level_q;
        frame_start_d = w_wrap;

        if (cfg_we) begin
            n_pend_d = cfg_n;
            m_pend_d = cfg_m;
        end

        if (!w_stall) begin
            hist_d[ptr_q] = w_new_hist;
            ptr_d         = (ptr_q == C_LAST) ? '0 : ptr_q + C_PW'(1);

            if (w_toggle) begin
                clean_d[ptr_q] = !w_cur_clean;
                evt_valid_d    = 1'b1;
                evt_ch_d       = ptr_q;
                evt_level_d    = !w_cur_clean;
            end else if (evt_valid_q) begin
                // Not stalled with valid high means the consumer took it
                evt_valid_d = 1'b0;
            end
        end

        if (w_wrap) begin
            n_act_d = n_pend_q;
            m_act_d = m_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            hist_q        <= '0;
            clean_q       <= '0;
            n_pend_q      <= C_NDEF;
            m_pend_q      <= C_MDEF;
            n_act_q       <= C_NDEF;
            m_act_q       <= C_MDEF;
            evt_valid_q   <= 1'b0;
            evt_ch_q      <= '0;
            evt_level_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            hist_q        <= hist_d;
            clean_q       <= clean_d;
            n_pend_q      <= n_pend_d;
            m_pend_q      <= m_pend_d;
            n_act_q       <= n_act_d;
            m_act_q       <= m_act_d;
            evt_valid_q   <= evt_valid_d;
            evt_ch_q      <= evt_ch_d;
            evt_level_q   <= evt_level_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign clean       = clean_q;
    assign evt_valid   = evt_valid_q;
    assign evt_ch      = evt_ch_q;
    assign evt_level   = evt_level_q;
    assign frame_start = frame_start_q;

`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
    logic [CH-1:0] irq_pend_q, irq_pend_d;
    logic [CH-1:0] w_irq_set;

    // Set has priority over a simultaneous clear of the same bit
    always_comb begin
        w_irq_set = '0;
        if (!w_stall && w_toggle) begin
            w_irq_set[ptr_q] = 1'b1;
        end
        irq_pend_d = (irq_pend_q & ~irq_clr) | w_irq_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend_q <= '0;
        end else begin
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_pend = irq_pend_q;
    assign irq      = |irq_pend_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_antiglitch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_antiglitch_bank_ctrl
// Purpose  : Directed self-checking bench for antiglitch_bank_ctrl (CH=8, MMAX=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_antiglitch_bank_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] glitch;
    logic       cfg_we;
    logic [4:0] cfg_n;
    logic [4:0] cfg_m;
    logic [7:0] clean;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_ch;
    logic       evt_level;
    logic       frame_start;
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
    logic [7:0] irq_pend;
    logic [7:0] irq_clr;
    logic       irq;
`endif

    int n_cmp;
    int n_bad;
    bit evt_seen;

    antiglitch_bank_ctrl #(
        .CH    (8),
        .MMAX  (16),
        .N_DEF (3),
        .M_DEF (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .glitch      (glitch),
        .cfg_we      (cfg_we),
        .cfg_n       (cfg_n),
        .cfg_m       (cfg_m),
        .clean       (clean),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_level   (evt_level),
        .frame_start (frame_start)
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
        ,
        .irq_pend    (irq_pend),
        .irq_clr     (irq_clr),
        .irq         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (evt_valid) evt_seen = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        evt_seen  = 1'b0;
        rst       = 1'b1;
        glitch    = 8'h00;
        cfg_we    = 1'b0;
        cfg_n     = 5'd0;
        cfg_m     = 5'd0;
        evt_ready = 1'b1;
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
        irq_clr   = 8'h00;
`endif
        tick();
        tick();
        check("rst_clean", 32'(clean), 32'h00);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_ch", 32'(evt_ch), 32'h0);
        check("rst_evt_level", 32'(evt_level), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_ptr", 32'(dut.ptr_q), 32'h0);

        // Channel 0 held high: toggles on its third visit (edge 17)
        rst    = 1'b0;
        glitch = 8'h01;
        repeat (8) tick();
        check("f1_frame_start", 32'(frame_start), 32'h1);
        check("f1_clean", 32'(clean), 32'h00);
        tick();
        check("f2_frame_start_low", 32'(frame_start), 32'h0);
        repeat (7) tick();
        check("pre_toggle_clean", 32'(clean), 32'h00);
        check("pre_toggle_valid", 32'(evt_valid), 32'h0);
        tick();
        check("ch0_clean", 32'(clean), 32'h01);
        check("ch0_evt_valid", 32'(evt_valid), 32'h1);
        check("ch0_evt_ch", 32'(evt_ch), 32'h0);
        check("ch0_evt_level", 32'(evt_level), 32'h1);
        tick();
        check("ch0_evt_accepted", 32'(evt_valid), 32'h0);

        // Single-visit pulse on ch5 is rejected
        evt_seen = 1'b0;
        glitch   = 8'h21;
        repeat (4) tick();
        glitch   = 8'h01;
        repeat (16) tick();
        check("glitch_no_evt", 32'(evt_seen), 32'h0);
        check("glitch_clean", 32'(clean), 32'h01);

        // Backpressure: ch2 event stalls the scan at ptr 3
        evt_ready = 1'b0;
        glitch    = 8'h0D;
        repeat (20) tick();
        check("bp_pre_clean", 32'(clean), 32'h01);
        check("bp_pre_valid", 32'(evt_valid), 32'h0);
        tick();
        check("bp_ch2_valid", 32'(evt_valid), 32'h1);
        check("bp_ch2_ch", 32'(evt_ch), 32'h2);
        check("bp_ch2_level", 32'(evt_level), 32'h1);
        check("bp_ch2_clean", 32'(clean), 32'h05);
        check("bp_ptr_at3", 32'(dut.ptr_q), 32'h3);
        repeat (20) tick();
        check("bp_hold_valid", 32'(evt_valid), 32'h1);
        check("bp_hold_ch", 32'(evt_ch), 32'h2);
        check("bp_hold_clean", 32'(clean), 32'h05);
        check("bp_hold_ptr", 32'(dut.ptr_q), 32'h3);
        evt_ready = 1'b1;
        tick();
        check("bp_ch3_valid", 32'(evt_valid), 32'h1);
        check("bp_ch3_ch", 32'(evt_ch), 32'h3);
        check("bp_ch3_level", 32'(evt_level), 32'h1);
        check("bp_ch3_clean", 32'(clean), 32'h0D);
        tick();
        check("bp_drain_valid", 32'(evt_valid), 32'h0);
        check("bp_drain_ptr", 32'(dut.ptr_q), 32'h5);

        // Mid-frame write N=1,M=1: old config until the wrap
        cfg_we = 1'b1;
        cfg_n  = 5'd1;
        cfg_m  = 5'd1;
        glitch = 8'hCD;
        tick();
        cfg_we = 1'b0;
        tick();
        check("cfg_old_ch6_clean", 32'(clean), 32'h0D);
        tick();
        check("cfg_old_ch7_clean", 32'(clean), 32'h0D);
        check("cfg_old_valid", 32'(evt_valid), 32'h0);
        check("cfg_wrap_frame_start", 32'(frame_start), 32'h1);
        glitch = 8'hCC;
        tick();
        check("pt_ch0_clean", 32'(clean), 32'h0C);
        check("pt_ch0_ch", 32'(evt_ch), 32'h0);
        check("pt_ch0_level", 32'(evt_level), 32'h0);
        check("pt_frame_start_low", 32'(frame_start), 32'h0);
        repeat (6) tick();
        check("pt_ch6_clean", 32'(clean), 32'h4C);
        check("pt_ch6_ch", 32'(evt_ch), 32'h6);
        tick();
        check("pt_ch7_clean", 32'(clean), 32'hCC);
        check("pt_ch7_valid", 32'(evt_valid), 32'h1);
        check("pt_ch7_ch", 32'(evt_ch), 32'h7);

        // cfg_n=0 acts as N=1 with M=4
        repeat (24) tick();
        cfg_we = 1'b1;
        cfg_n  = 5'd0;
        cfg_m  = 5'd4;
        tick();
        cfg_we = 1'b0;
        repeat (7) tick();
        check("n0_wrap", 32'(frame_start), 32'h1);
        evt_seen = 1'b0;
        repeat (8) tick();
        check("n0_steady_no_evt", 32'(evt_seen), 32'h0);
        check("n0_steady_clean", 32'(clean), 32'hCC);
        glitch = 8'hCD;
        tick();
        check("n0_ch0_clean", 32'(clean), 32'hCD);
        check("n0_ch0_ch", 32'(evt_ch), 32'h0);
        check("n0_ch0_level", 32'(evt_level), 32'h1);

        // cfg_m=31 acts as M=16; N=16 needs sixteen agreeing samples
        cfg_we = 1'b1;
        cfg_n  = 5'd16;
        cfg_m  = 5'd31;
        tick();
        cfg_we = 1'b0;
        repeat (6) tick();
        glitch   = 8'hCF;
        evt_seen = 1'b0;
        repeat (121) tick();
        check("m31_15_no_evt", 32'(evt_seen), 32'h0);
        check("m31_15_clean", 32'(clean), 32'hCD);
        tick();
        check("m31_16_clean", 32'(clean), 32'hCF);
        check("m31_16_ch", 32'(evt_ch), 32'h1);
        check("m31_16_level", 32'(evt_level), 32'h1);
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
        check("irq_pend_acc", 32'(irq_pend), 32'hCF);
        check("irq_high", 32'(irq), 32'h1);
        irq_clr = 8'hFF;
`endif

        // N=5 > M=4: never toggles
        cfg_we = 1'b1;
        cfg_n  = 5'd5;
        cfg_m  = 5'd4;
        tick();
        cfg_we = 1'b0;
`ifdef ANTIGLITCH_BANK_CTRL_IRQ_EN
        irq_clr = 8'h00;
        check("irq_pend_cleared", 32'(irq_pend), 32'h00);
        check("irq_low", 32'(irq), 32'h0);
`endif
        repeat (5) tick();
        check("n5m4_wrap", 32'(frame_start), 32'h1);
        glitch   = 8'hDF;
        evt_seen = 1'b0;
        repeat (80) tick();
        check("n5m4_no_evt", 32'(evt_seen), 32'h0);
        check("n5m4_clean", 32'(clean), 32'hCF);

        // Reset restores histories, pointer and default 3-of-4
        rst    = 1'b1;
        glitch = 8'h00;
        tick();
        check("rst2_clean", 32'(clean), 32'h00);
        check("rst2_valid", 32'(evt_valid), 32'h0);
        check("rst2_ptr", 32'(dut.ptr_q), 32'h0);
        rst    = 1'b0;
        glitch = 8'h01;
        repeat (16) tick();
        check("rst2_pre_clean", 32'(clean), 32'h00);
        tick();
        check("rst2_def_clean", 32'(clean), 32'h01);
        check("rst2_def_ch", 32'(evt_ch), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
